// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

endpackage

// File: rtl/lsu_mem_port_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge, legality check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic        bad_f3;
  logic        misaligned;

  always_comb begin
    shifted = word_in >> {addr_lo, 3'b000};
    unique case (funct3)
      F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_val = {24'h0, shifted[7:0]};
      F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_val = {16'h0, shifted[15:0]};
      default: load_val = word_in;
    endcase
  end

  // funct3[0] selects halfword vs byte lane for SB/SH
  always_comb begin
    if (funct3[0]) begin
      lane_mask = 32'h0000_FFFF << {addr_lo[1], 4'b0000};
      lane_data = (wdata & 32'h0000_FFFF) << {addr_lo[1], 4'b0000};
    end else begin
      lane_mask = 32'h0000_00FF << {addr_lo, 3'b000};
      lane_data = (wdata & 32'h0000_00FF) << {addr_lo, 3'b000};
    end
    store_word = (word_in & ~lane_mask) | (lane_data & lane_mask);
  end

  // 011 is not a store encoding either, so it is rejected for both directions
  always_comb begin
    bad_f3     = we ? (funct3[2] || funct3 == 3'b011)
                    : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) ||
                 (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
    illegal    = bad_f3 || misaligned;
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: one request at a time onto a word-only RAM, RMW for SB/SH.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              idle, hs, wr_en;
  logic [DATA_W-1:0] load_val, store_word;
  logic              illegal;

  assign idle = (state_q == IDLE);
  assign hs   = req_valid && req_ready;

  // In IDLE the aligner checks the incoming request; afterwards it works on latched fields
  lsu_align u_align (
    .we         (idle ? req_we : we_q),
    .funct3     (idle ? req_funct3 : f3_q),
    .addr_lo    (idle ? req_addr[1:0] : addr_q[1:0]),
    .word_in    ((state_q == WRITE) ? merge_q : mem_rdata),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word),
    .illegal    (illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (hs) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (illegal) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        err_d = 1'b0;
        if (!we_q) begin
          rdata_d = load_val;
          state_d = RESP;
        end else if (f3_q == F3_W) begin
          rdata_d = '0;
          state_d = RESP;
        end else begin
          rdata_d = '0;
          merge_d = mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = idle && !reset;
    rsp_valid = (state_q == RESP) && !reset;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wdata = '0;
    wr_en     = 1'b0;
    if (state_q == ACCESS && we_q && f3_q == F3_W) begin
      mem_wdata = wdata_q;
      wr_en     = 1'b1;
    end else if (state_q == WRITE) begin
      mem_wdata = store_word;
      wr_en     = 1'b1;
    end
    mem_write = wr_en && !reset;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: directed requests, monitor checks responses and RAM writes.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  typedef struct { int cyc; logic [31:0] rdata; logic err; } rsp_exp_t;
  typedef struct { int cyc; logic [9:0] idx; logic [31:0] data; } wr_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;

  logic [31:0] ram [0:1023];
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  rsp_exp_t sq[$];
  wr_exp_t  wq[$];

  lsu_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = ram[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr[11:2]] <= mem_wdata;
    else if (bd_we) ram[bd_idx] <= bd_data;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops an expectation whenever the DUT shows a response or a write
  initial forever begin
    @(negedge clk);
    #2;
    if (rsp_valid) begin
      if (sq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        rsp_exp_t e;
        e = sq.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
    if (mem_write) begin
      if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        wr_exp_t w;
        w = wq.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_index", {22'd0, mem_addr[11:2]}, {22'd0, w.idx});
        chk("wr_data", mem_wdata, w.data);
      end
    end
  end

  task automatic backdoor(input logic [9:0] idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Called at a negedge; returns the handshake cycle
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold, output int c);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    c = cyc;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                    input logic err, input bit hold);
    int c;
    issue(1'b0, f3, a, 32'h0, hold, c);
    if (err) sq.push_back('{c + 1, 32'h0, 1'b1});
    else     sq.push_back('{c + 2, exp, 1'b0});
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_word, input logic err);
    int c;
    issue(1'b1, f3, a, wd, 1'b0, c);
    if (err) sq.push_back('{c + 1, 32'h0, 1'b1});
    else if (f3 == F3_W) begin
      wq.push_back('{c + 1, a[11:2], exp_word});
      sq.push_back('{c + 2, 32'h0, 1'b0});
    end else begin
      wq.push_back('{c + 2, a[11:2], exp_word});
      sq.push_back('{c + 3, 32'h0, 1'b0});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(negedge clk); n++;
    end
    if (sq.size() != 0 || wq.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int c;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_mem_write", {31'd0, mem_write}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    backdoor(10'h40, 32'hDEADBEEF);
    ld(F3_W, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0); drain();

    backdoor(10'h40, 32'h80AABBCC);
    ld(F3_B,  32'h103, 32'hFFFFFF80, 1'b0, 1'b0); drain();
    ld(F3_BU, 32'h103, 32'h00000080, 1'b0, 1'b0); drain();
    ld(F3_HU, 32'h102, 32'h000080AA, 1'b0, 1'b0); drain();
    ld(F3_H,  32'h102, 32'hFFFF80AA, 1'b0, 1'b0); drain();
    ld(F3_B,  32'h100, 32'hFFFFFFCC, 1'b0, 1'b0); drain();
    ld(F3_HU, 32'h100, 32'h0000BBCC, 1'b0, 1'b0); drain();

    backdoor(10'h40, 32'hAABBCCDD);
    st(F3_B, 32'h101, 32'h12345677, 32'hAABB77DD, 1'b0); drain();
    ld(F3_W, 32'h100, 32'hAABB77DD, 1'b0, 1'b0); drain();

    backdoor(10'h40, 32'h11223344);
    st(F3_H, 32'h102, 32'hFFFF1234, 32'h12343344, 1'b0); drain();
    ld(F3_W, 32'h106, 32'h0, 1'b1, 1'b0); drain();
    ld(F3_W, 32'h100, 32'h12343344, 1'b0, 1'b0); drain();

    st(F3_W, 32'h108, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0); drain();
    ld(F3_W, 32'h108, 32'hCAFEF00D, 1'b0, 1'b0); drain();

    ld(3'b011, 32'h100, 32'h0, 1'b1, 1'b0); drain();
    st(3'b100, 32'h100, 32'h1, 32'h0, 1'b1); drain();
    ld(F3_H,  32'h101, 32'h0, 1'b1, 1'b0); drain();
    st(F3_W,  32'h102, 32'h1, 32'h0, 1'b1); drain();

    // req_valid held across two requests; only accepted while req_ready
    ld(F3_W,  32'h100, 32'h12343344, 1'b0, 1'b1);
    ld(F3_BU, 32'h101, 32'h00000033, 1'b0, 1'b0);
    drain();

    // reset while an SH is in WRITE: no write, no response
    backdoor(10'h42, 32'h55667788);
    issue(1'b1, F3_H, 32'h10A, 32'h0000BEEF, 1'b0, c);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_ram_kept", ram[10'h42], 32'h55667788);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
